// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 32-bit-word unified main memory between the data cache and the
// instruction cache. A data-cache block read or write is a single memory beat.
// An instruction-cache block fill is a 4-beat burst of word reads assembled
// into one 128-bit block. When both caches want the memory, the arbiter
// alternates between them (round-robin). Each cache sees its usual
// READ/WRITE/BUSYWAIT handshake.
//
// Parameters
//   MEM_AW  word-address width of the unified memory
//   IBASE   word base of the instruction region (I block n -> IBASE+4n..+3)
//   DBASE   word base of the data region        (D block n -> DBASE+n)
//
// Ports
//   CLK, RESET_N         clock (posedge) and asynchronous active-low reset
//   D_READ / D_WRITE     dcache block request, held until D_BUSYWAIT drops
//   D_ADDRESS            dcache block address (6 bits)
//   D_WRITEDATA          dcache write word
//   D_READDATA           dcache read word, holds until the next D read
//   D_BUSYWAIT           dcache stall (combinational)
//   I_READ / I_ADDRESS   icache fill request and block address
//   I_READDATA           icache 128-bit block, beat k in bits [32k+31:32k]
//   I_BUSYWAIT           icache stall (combinational)
//   M_READ / M_WRITE     memory word strobes (registered)
//   M_ADDRESS            memory word address (registered)
//   M_WRITEDATA          memory write word (registered)
//   M_READDATA           memory read word
//   M_BUSYWAIT           memory busy; low in the cycle a beat completes
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned IBASE  = 0,
    parameter int unsigned DBASE  = 256
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [5:0]        D_ADDRESS,
    input  logic [31:0]       D_WRITEDATA,
    output logic [31:0]       D_READDATA,
    output logic              D_BUSYWAIT,
    input  logic              I_READ,
    input  logic [5:0]        I_ADDRESS,
    output logic [127:0]      I_READDATA,
    output logic              I_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [MEM_AW-1:0] M_ADDRESS,
    output logic [31:0]       M_WRITEDATA,
    input  logic [31:0]       M_READDATA,
    input  logic              M_BUSYWAIT
);

    typedef enum logic [2:0] {
        IDLE,
        D_ACC,
        D_DONE,
        I_ACC,
        I_GAP,
        I_DONE
    } state_t;

    typedef enum logic {
        GRANT_D,
        GRANT_I
    } grant_t;

    localparam logic [MEM_AW-1:0] IBASE_W = MEM_AW'(IBASE);
    localparam logic [MEM_AW-1:0] DBASE_W = MEM_AW'(DBASE);

    state_t            state;
    state_t            next_state;
    grant_t            last_grant;
    grant_t            next_last_grant;
    logic [1:0]        beat;
    logic [1:0]        next_beat;
    logic [5:0]        i_block;
    logic [5:0]        next_i_block;
    logic              next_m_read;
    logic              next_m_write;
    logic [MEM_AW-1:0] next_m_address;
    logic [31:0]       next_m_writedata;
    logic              capture_d;
    logic              capture_i;
    logic              d_req;
    logic              i_req;
    logic              pick_d;

    // Word address of beat b of instruction block blk; wraps modulo 2^MEM_AW.
    function automatic logic [MEM_AW-1:0] i_word(input logic [5:0] blk, input logic [1:0] b);
        return IBASE_W + MEM_AW'({blk, b});
    endfunction

    assign d_req = D_READ | D_WRITE;
    assign i_req = I_READ;

    // On a tie the data side wins unless it was the one served last.
    assign pick_d = d_req & (~i_req | (last_grant == GRANT_I));

    // Stalls are raw combinational functions of the request, so they track the
    // request even while reset is held; they drop only in the DONE cycle.
    assign D_BUSYWAIT = d_req & (state != D_DONE);
    assign I_BUSYWAIT = i_req & (state != I_DONE);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            beat       <= 2'd0;
            i_block    <= 6'd0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
            beat       <= next_beat;
            i_block    <= next_i_block;
        end
    end

    // Next-state and next memory-interface values. The memory strobes, address
    // and write data are registered, so the values chosen here appear on the
    // memory port during the cycle after the decision.
    always_comb begin
        next_state       = state;
        next_last_grant  = last_grant;
        next_beat        = beat;
        next_i_block     = i_block;
        next_m_read      = M_READ;
        next_m_write     = M_WRITE;
        next_m_address   = M_ADDRESS;
        next_m_writedata = M_WRITEDATA;
        capture_d        = 1'b0;
        capture_i        = 1'b0;

        case (state)
            IDLE: begin
                if (pick_d) begin
                    // Write has priority over read if a cache raises both.
                    next_state     = D_ACC;
                    next_m_write   = D_WRITE;
                    next_m_read    = ~D_WRITE;
                    next_m_address = DBASE_W + MEM_AW'(D_ADDRESS);
                    if (D_WRITE) begin
                        next_m_writedata = D_WRITEDATA;
                    end
                end else if (i_req) begin
                    next_state     = I_ACC;
                    next_m_read    = 1'b1;
                    next_m_write   = 1'b0;
                    next_beat      = 2'd0;
                    next_i_block   = I_ADDRESS;
                    next_m_address = i_word(I_ADDRESS, 2'd0);
                end
            end

            D_ACC: begin
                if (!M_BUSYWAIT) begin
                    capture_d    = M_READ;
                    next_m_read  = 1'b0;
                    next_m_write = 1'b0;
                    next_state   = D_DONE;
                end
            end

            D_DONE: begin
                next_last_grant = GRANT_D;
                next_state      = IDLE;
            end

            I_ACC: begin
                if (!M_BUSYWAIT) begin
                    capture_i   = 1'b1;
                    next_m_read = 1'b0;
                    if (beat == 2'd3) begin
                        next_beat  = 2'd0;
                        next_state = I_DONE;
                    end else begin
                        next_beat  = beat + 2'd1;
                        next_state = I_GAP;
                    end
                end
            end

            // One idle cycle between beats lets the memory see the strobe drop
            // and re-arm for the next word.
            I_GAP: begin
                next_m_read    = 1'b1;
                next_m_address = i_word(i_block, beat);
                next_state     = I_ACC;
            end

            I_DONE: begin
                next_last_grant = GRANT_I;
                next_state      = IDLE;
            end

            default: begin
                next_state   = IDLE;
                next_m_read  = 1'b0;
                next_m_write = 1'b0;
            end
        endcase
    end

    // Memory-port registers and the read-data holding registers. Reset clears
    // them asynchronously, which also drops the strobes immediately and throws
    // away any partially assembled instruction block.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= 32'd0;
            D_READDATA  <= 32'd0;
            I_READDATA  <= 128'd0;
        end else begin
            M_READ      <= next_m_read;
            M_WRITE     <= next_m_write;
            M_ADDRESS   <= next_m_address;
            M_WRITEDATA <= next_m_writedata;
            if (capture_d) begin
                D_READDATA <= M_READDATA;
            end
            if (capture_i) begin
                I_READDATA[{beat, 5'b00000} +: 32] <= M_READDATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A word-addressed memory model with a
// programmable busy latency sits on the memory port and logs every completed
// beat. A transaction-level reference model predicts, from the arbitration
// rules, which cache is served first, the exact list of memory beats, the
// cycle at which each BUSYWAIT drops, the number of strobe cycles and the
// returned data. Directed scenarios come first, then randomized ones.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MEM_AW = 10;
    localparam int IBASE  = 0;
    localparam int DBASE  = 256;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          D_READ;
    logic          D_WRITE;
    logic [5:0]    D_ADDRESS;
    logic [31:0]   D_WRITEDATA;
    logic [31:0]   D_READDATA;
    logic          D_BUSYWAIT;
    logic          I_READ;
    logic [5:0]    I_ADDRESS;
    logic [127:0]  I_READDATA;
    logic          I_BUSYWAIT;
    logic          M_READ;
    logic          M_WRITE;
    logic [9:0]    M_ADDRESS;
    logic [31:0]   M_WRITEDATA;
    logic [31:0]   M_READDATA;
    logic          M_BUSYWAIT;

    mem_arbiter #(
        .MEM_AW(MEM_AW),
        .IBASE (IBASE),
        .DBASE (DBASE)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .D_READ     (D_READ),
        .D_WRITE    (D_WRITE),
        .D_ADDRESS  (D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA (D_READDATA),
        .D_BUSYWAIT (D_BUSYWAIT),
        .I_READ     (I_READ),
        .I_ADDRESS  (I_ADDRESS),
        .I_READDATA (I_READDATA),
        .I_BUSYWAIT (I_BUSYWAIT),
        .M_READ     (M_READ),
        .M_WRITE    (M_WRITE),
        .M_ADDRESS  (M_ADDRESS),
        .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA (M_READDATA),
        .M_BUSYWAIT (M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Power-up contents of the unified memory.
    function automatic logic [31:0] init_word(input logic [9:0] a);
        if (a < 10'd256) begin
            return 32'(a) + 32'd8;
        end
        return 32'hA5A50000 + 32'(a) - 32'd260;
    endfunction

    // Memory model: busy for mem_lat cycles after a strobe rises, then one
    // cycle with busy low in which the beat completes.
    int          mem_lat = 0;
    int          busy_cnt = 0;
    int          strobe_cycles = 0;
    logic [31:0] wr_data [0:1023];
    bit          written [0:1023];
    acc_t        acc_q[$];

    assign M_BUSYWAIT = (M_READ | M_WRITE) && (busy_cnt < mem_lat);
    assign M_READDATA = written[M_ADDRESS] ? wr_data[M_ADDRESS] : init_word(M_ADDRESS);

    always @(posedge CLK) begin
        if (M_READ || M_WRITE) begin
            strobe_cycles <= strobe_cycles + 1;
            if (!M_BUSYWAIT) begin
                busy_cnt <= 0;
                if (M_WRITE) begin
                    wr_data[M_ADDRESS] <= M_WRITEDATA;
                    written[M_ADDRESS] <= 1'b1;
                end
                acc_q.push_back('{wr: M_WRITE, addr: M_ADDRESS,
                                  data: (M_WRITE ? M_WRITEDATA : M_READDATA)});
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    // Reference model state.
    int           checks = 0;
    int           errors = 0;
    bit           model_last_i;
    logic [31:0]  model_d_rd;
    logic [127:0] model_i_rd;
    logic [31:0]  ref_mem [0:1023];

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one scenario from a negedge with the arbiter idle: optional D
    // request (raised d_delay cycles in if nonzero), optional I fill, memory
    // latency lat. Predicts everything first, then drives and checks.
    task automatic applyStimulus(input string tag, input bit do_d, input bit d_wr,
                                 input logic [5:0] d_addr, input logic [31:0] d_wd,
                                 input int d_delay, input bit do_i,
                                 input logic [5:0] i_addr, input int lat);
        acc_t       exp_q[$];
        acc_t       d_acc;
        acc_t       i_acc[$];
        bit         d_first;
        bit         d_pend;
        bit         i_pend;
        bit         d_raised;
        int         lat_d;
        int         lat_i;
        int         exp_d_n;
        int         exp_i_n;
        int         n_d;
        int         n_i;
        int         base;
        int         strobe0;
        int         exp_strobe;
        logic [9:0] d_word;
        logic [9:0] w;

        mem_lat = lat;
        lat_d   = lat + 2;
        lat_i   = 4 * lat + 8;
        d_first = do_d && (d_delay == 0) && (!do_i || model_last_i);
        d_word  = 10'((DBASE + int'(d_addr)) % 1024);

        if (do_d) begin
            if (d_wr) begin
                d_acc = '{wr: 1'b1, addr: d_word, data: d_wd};
                ref_mem[d_word] = d_wd;
            end else begin
                d_acc = '{wr: 1'b0, addr: d_word, data: ref_mem[d_word]};
                model_d_rd = ref_mem[d_word];
            end
        end
        if (do_i) begin
            for (int k = 0; k < 4; k++) begin
                w = 10'((IBASE + 4 * int'(i_addr) + k) % 1024);
                i_acc.push_back('{wr: 1'b0, addr: w, data: ref_mem[w]});
                model_i_rd[32*k +: 32] = ref_mem[w];
            end
        end
        if (do_d && d_first) exp_q.push_back(d_acc);
        foreach (i_acc[k]) exp_q.push_back(i_acc[k]);
        if (do_d && !d_first) exp_q.push_back(d_acc);

        exp_d_n = lat_d;
        exp_i_n = lat_i;
        if (do_d && do_i) begin
            if (d_first) exp_i_n = lat_d + 1 + lat_i;
            else         exp_d_n = lat_i + 1 + lat_d;
        end
        exp_strobe = (do_d ? lat + 1 : 0) + (do_i ? 4 * (lat + 1) : 0);
        model_last_i = do_i && (!do_d || d_first);

        base        = acc_q.size();
        strobe0     = strobe_cycles;
        I_READ      = do_i;
        I_ADDRESS   = i_addr;
        D_ADDRESS   = d_addr;
        D_WRITEDATA = d_wd;
        d_raised    = 1'b0;
        if (do_d && d_delay == 0) begin
            D_READ   = !d_wr;
            D_WRITE  = d_wr;
            d_raised = 1'b1;
        end
        d_pend = do_d;
        i_pend = do_i;
        n_d    = -1;
        n_i    = -1;
        for (int cyc = 1; cyc <= 400 && (d_pend || i_pend); cyc++) begin
            @(negedge CLK);
            if (d_pend && d_raised && !D_BUSYWAIT) begin
                n_d     = cyc;
                d_pend  = 1'b0;
                D_READ  = 1'b0;
                D_WRITE = 1'b0;
                checkOutput({tag, " d_readdata"}, 128'(D_READDATA), 128'(model_d_rd));
            end
            if (i_pend && !I_BUSYWAIT) begin
                n_i    = cyc;
                i_pend = 1'b0;
                I_READ = 1'b0;
                checkOutput({tag, " i_readdata"}, I_READDATA, model_i_rd);
            end
            if (do_d && !d_raised && cyc == d_delay) begin
                D_READ   = !d_wr;
                D_WRITE  = d_wr;
                d_raised = 1'b1;
            end
        end
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
        I_READ  = 1'b0;

        checkOutput({tag, " timeout"}, 128'({d_pend, i_pend}), 128'(0));
        if (do_d) checkOutput({tag, " d_latency"}, 128'(n_d), 128'(exp_d_n));
        if (do_i) checkOutput({tag, " i_latency"}, 128'(n_i), 128'(exp_i_n));
        checkOutput({tag, " strobe_cycles"}, 128'(strobe_cycles - strobe0), 128'(exp_strobe));
        checkOutput({tag, " access_count"}, 128'(acc_q.size() - base), 128'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (base + k < acc_q.size()) begin
                checkOutput($sformatf("%s access%0d", tag, k), 128'(acc_q[base + k]), 128'(exp_q[k]));
            end
        end
        @(negedge CLK);
    endtask

    task automatic doReset();
        @(negedge CLK);
        RESET_N = 1'b0;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
        I_READ  = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N      = 1'b1;
        model_last_i = 1'b1;
        model_d_rd   = 32'd0;
        model_i_rd   = 128'd0;
        @(negedge CLK);
    endtask

    int   strobe_start;
    int   base6;
    int   kind;
    int   lat;
    int   delay;
    bit   rd_d;
    bit   rd_i;

    initial begin
        RESET_N     = 1'b0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDRESS   = 6'd0;
        D_WRITEDATA = 32'd0;
        I_READ      = 1'b0;
        I_ADDRESS   = 6'd0;
        for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(10'(a));
        model_last_i = 1'b1;
        model_d_rd   = 32'd0;
        model_i_rd   = 128'd0;

        // Test 1: reset behaviour and a quiet idle period.
        repeat (2) @(negedge CLK);
        D_READ = 1'b1;
        #1 checkOutput("t1 d_busywait in reset", 128'(D_BUSYWAIT), 128'(1));
        I_READ = 1'b1;
        #1 checkOutput("t1 i_busywait in reset", 128'(I_BUSYWAIT), 128'(1));
        D_READ = 1'b0;
        I_READ = 1'b0;
        #1 checkOutput("t1 busywaits drop", 128'({D_BUSYWAIT, I_BUSYWAIT}), 128'(0));
        @(negedge CLK);
        RESET_N      = 1'b1;
        strobe_start = strobe_cycles;
        repeat (20) @(negedge CLK);
        checkOutput("t1 m_read", 128'(M_READ), 128'(0));
        checkOutput("t1 m_write", 128'(M_WRITE), 128'(0));
        checkOutput("t1 m_address", 128'(M_ADDRESS), 128'(0));
        checkOutput("t1 m_writedata", 128'(M_WRITEDATA), 128'(0));
        checkOutput("t1 d_readdata", 128'(D_READDATA), 128'(0));
        checkOutput("t1 i_readdata", I_READDATA, 128'(0));
        checkOutput("t1 d_busywait", 128'(D_BUSYWAIT), 128'(0));
        checkOutput("t1 i_busywait", 128'(I_BUSYWAIT), 128'(0));
        checkOutput("t1 no strobes", 128'(strobe_cycles - strobe_start), 128'(0));

        // Test 2: single data read with a slow memory.
        applyStimulus("t2", 1'b1, 1'b0, 6'h05, 32'd0, 0, 1'b0, 6'h00, 5);
        checkOutput("t2 data", 128'(D_READDATA), 128'(32'hA5A50001));

        // Test 3: instruction block fill.
        applyStimulus("t3", 1'b0, 1'b0, 6'h00, 32'd0, 0, 1'b1, 6'h02, 1);
        checkOutput("t3 block", I_READDATA, 128'h00000013_00000012_00000011_00000010);

        // Test 4: tie-breaking after reset, then alternation.
        doReset();
        applyStimulus("t4 pair1", 1'b1, 1'b1, 6'h3F, 32'hDEADBEEF, 0, 1'b1, 6'h07, 1);
        applyStimulus("t4 lone d", 1'b1, 1'b0, 6'h3F, 32'd0, 0, 1'b0, 6'h00, 1);
        checkOutput("t4 readback", 128'(D_READDATA), 128'(32'hDEADBEEF));
        applyStimulus("t4 pair2", 1'b1, 1'b0, 6'h01, 32'd0, 0, 1'b1, 6'h09, 0);

        // Test 5: data request raised in the middle of a burst.
        applyStimulus("t5", 1'b1, 1'b0, 6'h04, 32'd0, 6, 1'b1, 6'h01, 2);

        // Test 6: reset during beat 2 of a burst, then refetch from beat 0.
        mem_lat   = 2;
        base6     = acc_q.size();
        I_ADDRESS = 6'h03;
        I_READ    = 1'b1;
        for (int cyc = 0; cyc < 100 && !((acc_q.size() - base6) == 2 && M_READ); cyc++) begin
            @(negedge CLK);
        end
        checkOutput("t6 beat2 reached", 128'(acc_q.size() - base6), 128'(2));
        RESET_N = 1'b0;
        #1;
        checkOutput("t6 m_read drops", 128'(M_READ), 128'(0));
        checkOutput("t6 i_readdata cleared", I_READDATA, 128'(0));
        checkOutput("t6 i_busywait held", 128'(I_BUSYWAIT), 128'(1));
        repeat (2) @(negedge CLK);
        model_last_i = 1'b1;
        model_d_rd   = 32'd0;
        model_i_rd   = 128'd0;
        RESET_N      = 1'b1;
        applyStimulus("t6 refetch", 1'b0, 1'b0, 6'h00, 32'd0, 0, 1'b1, 6'h03, 2);

        // Randomized mix of lone, simultaneous and staggered requests.
        for (int it = 0; it < 40; it++) begin
            kind  = int'($urandom_range(0, 3));
            lat   = int'($urandom_range(0, 3));
            rd_d  = (kind != 1);
            rd_i  = (kind != 0);
            delay = (kind == 3) ? int'($urandom_range(1, 4 * lat + 7)) : 0;
            applyStimulus($sformatf("rnd%0d", it), rd_d, 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 7)), $urandom, delay, rd_i,
                          6'($urandom_range(0, 63)), lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
